// File: rtl/prog_nor_lut_pkg.sv
// Shared types and width helpers for the programmable NOR-LUT block.
package prog_nor_lut_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SWEEP = 2'd2
    } state_t;

    // Truth-table depth for an n_in-input function.
    function automatic int depth_of(input int n_in);
        return 1 << n_in;
    endfunction

    // Channel-select width; never narrower than one bit.
    function automatic int cw_of(input int n_func);
        return (n_func > 1) ? $clog2(n_func) : 1;
    endfunction

endpackage

// File: rtl/lut_table_bank.sv
// N_FUNC registered truth tables: parallel lookup, whole-table commit,
// and a single-channel bit read used by the minterm sweep.
module lut_table_bank
    import prog_nor_lut_pkg::*;
#(
    parameter int                      N_IN        = 4,
    parameter int                      N_FUNC      = 2,
    parameter logic [(1 << N_IN)-1:0]  RESET_TABLE = 16'h0717,
    localparam int                     DEPTH       = depth_of(N_IN),
    localparam int                     CW          = cw_of(N_FUNC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_IN-1:0]   rd_idx,
    output logic [N_FUNC-1:0] rd_f,
    input  logic              commit_en,
    input  logic [CW-1:0]     commit_chan,
    input  logic [DEPTH-1:0]  commit_data,
    input  logic [CW-1:0]     sw_chan,
    input  logic [N_IN-1:0]   sw_idx,
    output logic              sw_bit
);

    logic [DEPTH-1:0] tbl [N_FUNC];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_FUNC; k++) begin
                tbl[k] <= RESET_TABLE;
            end
        end else if (commit_en) begin
            for (int k = 0; k < N_FUNC; k++) begin
                if (CW'(k) == commit_chan) begin
                    tbl[k] <= commit_data;
                end
            end
        end
    end

    always_comb begin
        rd_f = '0;
        for (int k = 0; k < N_FUNC; k++) begin
            rd_f[k] = tbl[k][rd_idx];
        end
    end

    // Channel match instead of direct indexing keeps unused select codes harmless.
    always_comb begin
        sw_bit = 1'b0;
        for (int k = 0; k < N_FUNC; k++) begin
            if (CW'(k) == sw_chan) begin
                sw_bit = tbl[k][sw_idx];
            end
        end
    end

endmodule

// File: rtl/prog_nor_lut.sv
// Programmable N_FUNC x N_IN-input truth-table evaluator with serial table
// reload, registered valid/ready evaluation and a minterm-count sweep.
module prog_nor_lut
    import prog_nor_lut_pkg::*;
#(
    parameter int                      N_IN        = 4,
    parameter int                      N_FUNC      = 2,
    parameter logic [(1 << N_IN)-1:0]  RESET_TABLE = 16'h0717,
    localparam int                     DEPTH       = depth_of(N_IN),
    localparam int                     CW          = cw_of(N_FUNC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   in_x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_FUNC-1:0] out_f,
    input  logic              cfg_start,
    input  logic [CW-1:0]     cfg_chan,
    input  logic              cfg_bit_valid,
    input  logic              cfg_bit,
    output logic              cfg_done,
    output logic              cfg_err,
    input  logic              sweep_start,
    output logic              sweep_done,
    output logic [N_IN:0]     sweep_count,
    output logic              busy
);

    localparam logic [N_IN:0] IDX_LAST = (N_IN + 1)'(DEPTH - 1);
    localparam logic [N_IN:0] IDX_ONE  = (N_IN + 1)'(1);

    state_t              state_q, state_d;
    logic [N_IN:0]       idx_q;
    logic [CW-1:0]       chan_q;
    logic [DEPTH-1:0]    shadow_q;
    logic [N_IN:0]       acc_q;
    logic [N_IN:0]       acc_next;
    logic [N_IN:0]       sweep_count_q;
    logic                cfg_done_q, cfg_err_q, sweep_done_q;
    logic                cfg_done_d, cfg_err_d, sweep_done_d;
    logic                out_valid_q;
    logic [N_FUNC-1:0]   out_f_q;

    logic                go_load, go_sweep, bit_wr, sweep_step, commit_en;
    logic                chan_ok, idx_last, accept;
    logic [DEPTH-1:0]    commit_data;
    logic [N_FUNC-1:0]   rd_f;
    logic                sw_bit;

    // Handshake: a request transfers on in_valid && in_ready; a result
    // transfers on out_valid && out_ready; both may happen in one cycle.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    assign chan_ok  = int'(cfg_chan) < N_FUNC;
    assign idx_last = (idx_q == IDX_LAST);
    assign acc_next = acc_q + (N_IN + 1)'(sw_bit);

    // The final serial bit goes straight into the commit word, not via the shadow.
    always_comb begin
        commit_data            = shadow_q;
        commit_data[DEPTH-1]   = cfg_bit;
    end

    lut_table_bank #(
        .N_IN        (N_IN),
        .N_FUNC      (N_FUNC),
        .RESET_TABLE (RESET_TABLE)
    ) u_bank (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_idx      (in_x),
        .rd_f        (rd_f),
        .commit_en   (commit_en),
        .commit_chan (chan_q),
        .commit_data (commit_data),
        .sw_chan     (chan_q),
        .sw_idx      (idx_q[N_IN-1:0]),
        .sw_bit      (sw_bit)
    );

    always_comb begin
        state_d      = state_q;
        cfg_done_d   = 1'b0;
        cfg_err_d    = 1'b0;
        sweep_done_d = 1'b0;
        go_load      = 1'b0;
        go_sweep     = 1'b0;
        bit_wr       = 1'b0;
        sweep_step   = 1'b0;
        commit_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    if (chan_ok) begin
                        go_load = 1'b1;
                        state_d = ST_LOAD;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end else if (sweep_start) begin
                    if (chan_ok) begin
                        go_sweep = 1'b1;
                        state_d  = ST_SWEEP;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (cfg_bit_valid) begin
                    bit_wr = 1'b1;
                    if (idx_last) begin
                        commit_en  = 1'b1;
                        cfg_done_d = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_SWEEP: begin
                sweep_step = 1'b1;
                if (idx_last) begin
                    sweep_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            chan_q        <= '0;
            shadow_q      <= '0;
            acc_q         <= '0;
            sweep_count_q <= '0;
            cfg_done_q    <= 1'b0;
            cfg_err_q     <= 1'b0;
            sweep_done_q  <= 1'b0;
            out_valid_q   <= 1'b0;
            out_f_q       <= '0;
        end else begin
            state_q      <= state_d;
            cfg_done_q   <= cfg_done_d;
            cfg_err_q    <= cfg_err_d;
            sweep_done_q <= sweep_done_d;

            if (go_load || go_sweep) begin
                chan_q <= cfg_chan;
                idx_q  <= '0;
                acc_q  <= '0;
            end
            if (bit_wr) begin
                shadow_q[idx_q[N_IN-1:0]] <= cfg_bit;
                idx_q                     <= idx_q + IDX_ONE;
            end
            if (sweep_step) begin
                acc_q <= acc_next;
                idx_q <= idx_q + IDX_ONE;
            end
            if (sweep_done_d) begin
                sweep_count_q <= acc_next;
            end

            // Lookup reads the committed tables, so a same-edge commit is not visible yet.
            if (accept) begin
                out_valid_q <= 1'b1;
                out_f_q     <= rd_f;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_f       = out_f_q;
    assign cfg_done    = cfg_done_q;
    assign cfg_err     = cfg_err_q;
    assign sweep_done  = sweep_done_q;
    assign sweep_count = sweep_count_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_prog_nor_lut.sv
// Self-checking bench for prog_nor_lut: directed cases, randomized traffic,
// and a per-cycle comparison against a behavioural model.
module tb_prog_nor_lut;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;
    bit   started = 1'b0;

    // ---------------- main DUT (default parameters) ----------------
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [3:0] in_x;
    logic [1:0] out_f;
    logic       cfg_start, cfg_chan, cfg_bit_valid, cfg_bit;
    logic       cfg_done, cfg_err, sweep_start, sweep_done, busy;
    logic [4:0] sweep_count;

    prog_nor_lut dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_x          (in_x),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_f         (out_f),
        .cfg_start     (cfg_start),
        .cfg_chan      (cfg_chan),
        .cfg_bit_valid (cfg_bit_valid),
        .cfg_bit       (cfg_bit),
        .cfg_done      (cfg_done),
        .cfg_err       (cfg_err),
        .sweep_start   (sweep_start),
        .sweep_done    (sweep_done),
        .sweep_count   (sweep_count),
        .busy          (busy)
    );

    // ---------------- 3-channel DUT: makes an illegal channel encodable ----------------
    logic       e_in_ready, e_out_valid, e_cfg_done, e_cfg_err, e_sweep_done, e_busy;
    logic [2:0] e_out_f;
    logic [4:0] e_sweep_count;
    logic       e_cfg_start, e_sweep_start;
    logic [1:0] e_cfg_chan;

    prog_nor_lut #(.N_IN(4), .N_FUNC(3)) dut_e (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (1'b0),
        .in_ready      (e_in_ready),
        .in_x          (4'h0),
        .out_valid     (e_out_valid),
        .out_ready     (1'b1),
        .out_f         (e_out_f),
        .cfg_start     (e_cfg_start),
        .cfg_chan      (e_cfg_chan),
        .cfg_bit_valid (1'b0),
        .cfg_bit       (1'b0),
        .cfg_done      (e_cfg_done),
        .cfg_err       (e_cfg_err),
        .sweep_start   (e_sweep_start),
        .sweep_done    (e_sweep_done),
        .sweep_count   (e_sweep_count),
        .busy          (e_busy)
    );

    // ---------------- scoreboard counters ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference function from the hand-minimised expression, index {a,b,c,d}.
    function automatic logic nor_f(input logic [3:0] x);
        logic a, b, c, d;
        {a, b, c, d} = x;
        return (!b && !d) || (!b && !c) || (!a && !c && !d);
    endfunction

    // ---------------- behavioural model ----------------
    logic [15:0] m_tbl [2];
    logic [15:0] m_shadow;
    int          m_mode;    // 0 idle, 1 loading, 2 sweeping
    int          m_chan, m_cnt;
    logic        m_ov, m_rdy, m_done, m_err, m_sdone;
    logic [1:0]  m_of;
    logic [4:0]  m_scount;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tbl[0] = 16'h0717;
            m_tbl[1] = 16'h0717;
            m_shadow = '0;
            m_mode = 0; m_chan = 0; m_cnt = 0;
            m_ov = 0; m_of = '0; m_done = 0; m_err = 0; m_sdone = 0; m_scount = '0;
        end else begin
            m_rdy = !m_ov || out_ready;
            if (in_valid && m_rdy) begin
                m_ov = 1'b1;
                for (int k = 0; k < 2; k++) m_of[k] = m_tbl[k][in_x];
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            m_done = 0; m_err = 0; m_sdone = 0;
            case (m_mode)
                0: begin
                    if (cfg_start || sweep_start) begin
                        if (int'(cfg_chan) < 2) begin
                            m_mode = cfg_start ? 1 : 2;
                            m_chan = int'(cfg_chan);
                            m_cnt  = 0;
                        end else begin
                            m_err = 1'b1;
                        end
                    end
                end
                1: begin
                    if (cfg_bit_valid) begin
                        m_shadow[m_cnt] = cfg_bit;
                        m_cnt++;
                        if (m_cnt == 16) begin
                            m_tbl[m_chan] = m_shadow;
                            m_done = 1'b1;
                            m_mode = 0;
                        end
                    end
                end
                default: begin
                    m_cnt++;
                    if (m_cnt == 16) begin
                        m_scount = 5'($countones(m_tbl[m_chan]));
                        m_sdone  = 1'b1;
                        m_mode   = 0;
                    end
                end
            endcase
        end
    end

    // One compare process: every cycle out of reset, all outputs vs the model.
    always @(negedge clk) begin
        if (rst_n && started) begin
            chk("m_in_ready",    in_ready,    !m_ov || out_ready);
            chk("m_out_valid",   out_valid,   m_ov);
            chk("m_out_f",       out_f,       m_of);
            chk("m_busy",        busy,        m_mode != 0);
            chk("m_cfg_done",    cfg_done,    m_done);
            chk("m_cfg_err",     cfg_err,     m_err);
            chk("m_sweep_done",  sweep_done,  m_sdone);
            chk("m_sweep_count", sweep_count, m_scount);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic eval_get(input logic [3:0] x, output logic [1:0] got);
        in_valid  = 1'b1;
        in_x      = x;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        got       = out_f;
    endtask

    task automatic eval_one(input string nm, input logic [3:0] x, input logic [1:0] exp);
        logic [1:0] got;
        eval_get(x, got);
        chk(nm, got, exp);
        chk({nm, "_valid"}, out_valid, 1'b1);
    endtask

    task automatic check_ch0_reset(input string nm);
        logic [1:0] got;
        for (int x = 0; x < 16; x++) begin
            eval_get(4'(x), got);
            chk(nm, got[0], nor_f(4'(x)));
        end
    endtask

    task automatic load_tbl(input logic ch, input logic [15:0] val, input bit gaps,
                            input bit both, input bit probe, input logic [1:0] probe_exp);
        cfg_start   = 1'b1;
        sweep_start = both;
        cfg_chan    = ch;
        tick();
        cfg_start   = 1'b0;
        sweep_start = 1'b0;
        chk("load_busy", busy, 1'b1);
        for (int i = 0; i < 16; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            cfg_bit_valid = 1'b1;
            cfg_bit       = val[i];
            if (probe && i == 15) begin
                in_valid  = 1'b1;
                in_x      = 4'hF;
                out_ready = 1'b1;
            end
            tick();
            cfg_bit_valid = 1'b0;
            if (probe && i == 15) begin
                in_valid = 1'b0;
                chk("commit_cycle_old", out_f, probe_exp);
            end
        end
        chk("cfg_done_pulse", cfg_done, 1'b1);
        chk("load_idle", busy, 1'b0);
        tick();
        chk("cfg_done_once", cfg_done, 1'b0);
    endtask

    task automatic run_sweep(input logic ch, input logic [4:0] exp);
        int cyc = 0;
        sweep_start = 1'b1;
        cfg_chan    = ch;
        tick();
        sweep_start = 1'b0;
        while (!sweep_done && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("sweep_latency", cyc, 16);
        chk("sweep_count", sweep_count, exp);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [1:0] got;
        rst_n = 1'b0;
        in_valid = 0; in_x = '0; out_ready = 1'b1;
        cfg_start = 0; cfg_chan = 0; cfg_bit_valid = 0; cfg_bit = 0; sweep_start = 0;
        e_cfg_start = 0; e_sweep_start = 0; e_cfg_chan = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        started = 1'b1;

        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_f", out_f, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sweep_count", sweep_count, 5'd0);
        chk("rst_in_ready", in_ready, 1'b1);

        // Reset tables against the hand-derived expression.
        eval_one("rst_x0", 4'b0000, 2'b11);
        eval_one("rst_x3", 4'b0011, 2'b00);
        eval_one("rst_x4", 4'b0100, 2'b11);
        for (int x = 0; x < 16; x++) begin
            eval_get(4'(x), got);
            chk("rst_exhaustive", got, {nor_f(4'(x)), nor_f(4'(x))});
        end

        // Illegal channel on the 3-channel instance.
        e_cfg_chan = 2'd3; e_cfg_start = 1'b1;
        tick();
        e_cfg_start = 1'b0;
        chk("err_cfg_pulse", e_cfg_err, 1'b1);
        chk("err_cfg_busy", e_busy, 1'b0);
        tick();
        chk("err_cfg_clear", e_cfg_err, 1'b0);
        e_sweep_start = 1'b1;
        tick();
        e_sweep_start = 1'b0;
        chk("err_sweep_pulse", e_cfg_err, 1'b1);
        chk("err_sweep_busy", e_busy, 1'b0);
        e_cfg_chan = 2'd2; e_cfg_start = 1'b1;
        tick();
        e_cfg_start = 1'b0;
        chk("legal_chan2_busy", e_busy, 1'b1);
        chk("legal_chan2_no_err", e_cfg_err, 1'b0);

        // Backpressure: two requests, consumer stalled.
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_x      = 4'b0000;
        tick();
        in_x = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_out_f", out_f, 2'b11);
            chk("bp_out_valid", out_valid, 1'b1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("bp_second_result", out_f, 2'b00);
        chk("bp_second_valid", out_valid, 1'b1);
        tick();
        chk("bp_drained", out_valid, 1'b0);

        // Sweep of reset table, then reload channel 1 with gaps.
        run_sweep(1'b0, 5'd7);
        load_tbl(1'b1, 16'h8000, 1'b1, 1'b0, 1'b1, 2'b00);
        eval_one("ld_xF", 4'hF, 2'b10);
        eval_one("ld_x0", 4'h0, 2'b01);
        check_ch0_reset("ld_ch0_unchanged");

        // Simultaneous starts load only; all-ones sweep must not wrap.
        load_tbl(1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0, 2'b00);
        run_sweep(1'b0, 5'd16);

        // Reset mid-sweep clears the count.
        sweep_start = 1'b1; cfg_chan = 1'b1;
        tick();
        sweep_start = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        #10 rst_n = 1'b1;
        tick();
        chk("rst_sweep_count_zero", sweep_count, 5'd0);
        chk("rst_sweep_busy", busy, 1'b0);

        // Reset after 8 bits of a load restores the reset table.
        cfg_start = 1'b1; cfg_chan = 1'b0;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cfg_bit_valid = 1'b1; cfg_bit = 1'b1;
            tick();
        end
        cfg_bit_valid = 1'b0;
        rst_n = 1'b0;
        #10 rst_n = 1'b1;
        tick();
        chk("rst_load_busy", busy, 1'b0);
        chk("rst_load_no_done", cfg_done, 1'b0);
        check_ch0_reset("rst_load_table");

        // Randomized traffic checked by the model every cycle.
        for (int n = 0; n < 1500; n++) begin
            in_valid      = 1'($urandom_range(0, 1));
            in_x          = 4'($urandom_range(0, 15));
            out_ready     = ($urandom_range(0, 3) != 0);
            cfg_bit_valid = 1'($urandom_range(0, 1));
            cfg_bit       = 1'($urandom_range(0, 1));
            cfg_start     = ($urandom_range(0, 40) == 0);
            sweep_start   = ($urandom_range(0, 40) == 0);
            cfg_chan      = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid = 0; cfg_start = 0; sweep_start = 0;
        out_ready = 1'b1; cfg_bit_valid = 1'b1;
        repeat (20) tick();
        cfg_bit_valid = 1'b0;
        repeat (3) tick();
        chk("final_idle", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
